// File: rtl/nn_layer_sequencer.sv
// Sequences a chain of generated network layers: handshaked layers get a start pulse
// and are waited on, bypass (combinational) layers get one settle cycle.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_bypass,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_layer,
  output logic [IDX_W-1:0]      cur_layer,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [2:0]            dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cur_q, cur_d;
  logic [NUM_LAYERS-1:0]   byp_q, byp_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [IDX_W-1:0]        err_layer_q, err_layer_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    busy_s;
  logic                    last_layer;
  logic [IDX_W-1:0]        nxt_idx;
  state_t                  adv_state;
  logic [IDX_W-1:0]        adv_cur;

  // Layer handshake: layer_start is a one-cycle pulse issued from LAUNCH; the layer then
  // holds layer_done high (level) until its next start. done is only honoured in WAIT.
  assign busy_s     = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign last_layer = (cur_q == IDX_W'(NUM_LAYERS - 1));
  assign nxt_idx    = cur_q + IDX_W'(1);
  assign adv_state  = last_layer ? S_DONE : (byp_q[nxt_idx] ? S_NEXT : S_LAUNCH);
  assign adv_cur    = last_layer ? cur_q : nxt_idx;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    byp_d       = byp_q;
    tmr_d       = tmr_q;
    err_layer_d = err_layer_q;
    cnt_d       = cnt_q;

    if (busy_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          byp_d       = layer_bypass;
          cnt_d       = '0;
          err_layer_d = '0;
          cur_d       = '0;
          state_d     = layer_bypass[0] ? S_NEXT : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        tmr_d   = '0;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (layer_done[cur_q]) begin
          state_d = adv_state;
          cur_d   = adv_cur;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_ERR;
          err_layer_d = cur_q;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_NEXT: begin
        state_d = adv_state;
        cur_d   = adv_cur;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      cur_d       = cur_q;
      byp_d       = byp_q;
      tmr_d       = tmr_q;
      err_layer_d = err_layer_q;
      cnt_d       = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      byp_q       <= '0;
      tmr_q       <= '0;
      err_layer_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      byp_q       <= byp_d;
      tmr_q       <= tmr_d;
      err_layer_q <= err_layer_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    layer_start = '0;
    if (state_q == S_LAUNCH) begin
      layer_start[cur_q] = 1'b1;
    end
  end

  assign busy        = busy_s;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign err_layer   = err_layer_q;
  assign cur_layer   = cur_q;
  assign cycle_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: table-driven runs with a layer model and event scoreboard,
// plus hand-written timeout, abort and reset sequences.
module tb_nn_layer_sequencer;

  localparam int NL = 4;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int EW = 40;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NEXT = 3'd3;

  logic clk, rst_n;

  logic          start, abort;
  logic [NL-1:0] layer_bypass, layer_done, layer_start;
  logic          busy, done, error;
  logic [IW-1:0] err_layer, cur_layer;
  logic [CW-1:0] cycle_count;
  logic [2:0]    dbg_state;

  logic          start_t, abort_t;
  logic [NL-1:0] bypass_t, layer_done_t, ls_t;
  logic          busy_t, done_t, error_t;
  logic [IW-1:0] err_layer_t, cur_layer_t;
  logic [CW-1:0] cycle_count_t;
  logic [2:0]    dbg_state_t;

  nn_layer_sequencer #(.NUM_LAYERS(NL), .IDX_W(IW), .TIMEOUT_CYCLES(1023), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_bypass(layer_bypass), .layer_done(layer_done), .layer_start(layer_start),
    .busy(busy), .done(done), .error(error), .err_layer(err_layer),
    .cur_layer(cur_layer), .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  nn_layer_sequencer #(.NUM_LAYERS(NL), .IDX_W(IW), .TIMEOUT_CYCLES(8), .CNT_W(CW)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .start(start_t), .abort(abort_t),
    .layer_bypass(bypass_t), .layer_done(layer_done_t), .layer_start(ls_t),
    .busy(busy_t), .done(done_t), .error(error_t), .err_layer(err_layer_t),
    .cur_layer(cur_layer_t), .cycle_count(cycle_count_t), .dbg_state(dbg_state_t)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // layer model: done rises layer_delay cycles after the start pulse, drops on next start
  logic [NL-1:0] model_done, extra_done;
  int unsigned   rem [NL];
  int unsigned   layer_delay;
  assign layer_done = model_done | extra_done;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done <= '0;
      for (int i = 0; i < NL; i++) rem[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (layer_start[i]) begin
          model_done[i] <= 1'b0;
          rem[i]        <= layer_delay;
        end else if (rem[i] != 0) begin
          rem[i] <= rem[i] - 1;
          if (rem[i] == 1) model_done[i] <= 1'b1;
        end
      end
    end
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NL-1:0] bypass;
    int unsigned   dly;
    int unsigned   exp_done_cyc;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  // driver: start a run at the current negedge and compare every DUT event
  task automatic run_vector(input vec_t v, input int vi);
    int            c;
    bit            seen_done;
    logic [7:0]    tag;
    logic [15:0]   data;
    logic [EW-1:0] act, exp;
    layer_delay = v.dly;
    c = 1;
    for (int i = 0; i < NL; i++) begin
      if (v.bypass[i]) begin
        exp_q.push_back({8'h20, 16'(c), 16'(i)});
        c += 1;
      end else begin
        exp_q.push_back({8'(1 << i), 16'(c), 16'(i)});
        c += int'(v.dly) + 1;
      end
    end
    exp_q.push_back({8'h10, 16'(v.exp_done_cyc), 16'(v.exp_count)});
    start = 1'b1;
    layer_bypass = v.bypass;
    seen_done = 1'b0;
    for (int k = 1; k <= 300 && !seen_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) layer_bypass = ~v.bypass;
      if (layer_start != '0 || done || dbg_state == ST_NEXT) begin
        tag  = done ? 8'h10 : ((layer_start != '0) ? {4'h0, layer_start} : 8'h20);
        data = done ? 16'(cycle_count) : 16'(cur_layer);
        act  = {tag, 16'(k), data};
        exp  = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check($sformatf("v%0d_event", vi), act, exp);
        if (done) begin
          seen_done = 1'b1;
          check($sformatf("v%0d_busy_at_done", vi), busy, 1'b0);
        end
      end
    end
    if (!seen_done) check($sformatf("v%0d_done_timeout", vi), 0, 1);
    check($sformatf("v%0d_queue_empty", vi), exp_q.size(), 0);
    exp_q.delete();
    // start in the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_start_in_done_ignored", vi), {busy, layer_start}, '0);
    layer_bypass = '0;
  endtask

  initial begin
    bit got;
    vecs[0] = '{bypass: 4'b0000, dly: 16, exp_done_cyc: 69, exp_count: 16'd68};
    vecs[1] = '{bypass: 4'b0010, dly: 16, exp_done_cyc: 53, exp_count: 16'd52};
    vecs[2] = '{bypass: 4'b1111, dly: 16, exp_done_cyc: 5,  exp_count: 16'd4};
    vecs[3] = '{bypass: 4'b0101, dly: 3,  exp_done_cyc: 11, exp_count: 16'd10};
    vecs[4] = '{bypass: 4'b1000, dly: 1,  exp_done_cyc: 8,  exp_count: 16'd7};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; layer_bypass = '0; extra_done = '0;
    start_t = 1'b0; abort_t = 1'b0; bypass_t = '0; layer_done_t = '0; layer_delay = 16;
    repeat (3) @(negedge clk);
    check("reset_outputs", {layer_start, busy, done, error, err_layer, cur_layer, cycle_count}, '0);
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_outputs_to", {ls_t, busy_t, done_t, error_t, err_layer_t, cycle_count_t}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

    // watchdog: TIMEOUT_CYCLES=8, no done from the layer
    start_t = 1'b1; bypass_t = 4'b0000;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start_t = 1'b0;
      if (k == 1) check("to_launch_l0", ls_t, 4'b0001);
      if (k >= 2 && k <= 9) check($sformatf("to_wait_c%0d", k), {busy_t, error_t}, 2'b10);
      if (k == 10) begin
        check("to_err_flags", {error_t, busy_t, done_t, err_layer_t}, {1'b1, 1'b0, 1'b0, 2'd0});
        check("to_err_count", cycle_count_t, 16'd9);
      end
      if (k > 10) check($sformatf("to_err_held_c%0d", k), {error_t, done_t}, 2'b10);
    end
    // restart from ERR, time out on layer 2
    start_t = 1'b1; bypass_t = 4'b0011;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start_t = 1'b0;
      if (k == 1) check("to_rerun_clears_error", {error_t, busy_t}, 2'b01);
      if (k == 3) check("to_rerun_launch_l2", ls_t, 4'b0100);
      if (k == 12) check("to_rerun_err_l2", {error_t, err_layer_t}, {1'b1, 2'd2});
      if (k == 14) abort_t = 1'b1;
    end
    @(negedge clk);
    abort_t = 1'b0;
    check("to_abort_clears_error", {error_t, busy_t, dbg_state_t}, {1'b0, 1'b0, ST_IDLE});

    // abort during WAIT of L2, with ignored start and a stray done on a non-current layer
    layer_delay = 16; layer_bypass = '0;
    start = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      start      = (k == 20) || (k == 40) || (k == 41);
      abort      = (k == 40);
      extra_done = (k == 22) ? 4'b1000 : 4'b0000;
      if (k == 1)  check("ab_l0_start", layer_start, 4'b0001);
      if (k == 18) check("ab_l1_start", layer_start, 4'b0010);
      if (k == 21) check("ab_start_in_wait_ignored", {busy, cur_layer, layer_start}, {1'b1, 2'd1, 4'b0000});
      if (k == 23) check("ab_stray_done_ignored", {cur_layer, layer_start}, {2'd1, 4'b0000});
      if (k == 35) check("ab_l2_start", {cur_layer, layer_start}, {2'd2, 4'b0100});
      if (k == 41) check("ab_idle_after_abort", {busy, done, layer_start, dbg_state}, {1'b0, 1'b0, 4'b0000, ST_IDLE});
      if (k == 42) check("ab_restart_l0", {busy, cur_layer, layer_start}, {1'b1, 2'd0, 4'b0001});
    end
    start = 1'b0; abort = 1'b0;
    got = 1'b0;
    for (int k = 43; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check("ab_rerun_done_cycle", k, 110);
        check("ab_rerun_count", cycle_count, 16'd68);
      end
    end
    if (!got) check("ab_rerun_done_timeout", 0, 1);
    @(negedge clk);

    // asynchronous reset while in LAUNCH
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_launch", layer_start, 4'b0001);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", {layer_start, busy, done, error, err_layer, cur_layer, cycle_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
